// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl
// Game Boy CPU interrupt controller. Owns IE (0xFFFF), IF (0xFF0F) and the
// IME flag (with EI delay, DI and RETI), flags pending interrupts to the
// control unit, and runs the dispatch handshake that loads the interrupt
// vector into PC through the register file's overwrite port.
//
// Ports:
//   clk, reset                  machine clock, async active-low reset
//   irq_req[4:0]                one-cycle request pulses (bit 0 = VBlank, highest priority)
//   bus_addr/bus_wdata/bus_wren CPU data-bus write side
//   bus_rdata/bus_hit           combinational read data for IE/IF and address decode
//   ei_cmd/di_cmd/reti_cmd      one-cycle strobes from the control unit
//   instr_boundary              one-cycle strobe at each opcode fetch
//   dispatch_start              control unit begins the dispatch sequence
//   dispatch_vector_req         PC-load cycle within dispatch
//   int_pending, wake, ime      status to the control unit
//   write_interrupt_vector      one-cycle PC-load pulse
//   interrupt_vector            low byte of the selected vector
//   dbg_ime_state               IME FSM state (debug)
//   dbg_dispatch_state          dispatch FSM state (debug)
//
// Handshake: every *_cmd, instr_boundary, dispatch_* and irq_req input is a
// strobe sampled on the rising clk edge; write_interrupt_vector is high for
// exactly one cycle, the cycle after the accepted dispatch_vector_req.

module gb_cpu_interrupt_ctrl #(
  parameter int NUM_IRQ = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wdata,
  input  logic               bus_wren,
  output logic [7:0]         bus_rdata,
  output logic               bus_hit,
  input  logic               ei_cmd,
  input  logic               di_cmd,
  input  logic               reti_cmd,
  input  logic               instr_boundary,
  input  logic               dispatch_start,
  input  logic               dispatch_vector_req,
  output logic               int_pending,
  output logic               wake,
  output logic               ime,
  output logic               write_interrupt_vector,
  output logic [7:0]         interrupt_vector,
  output logic [1:0]         dbg_ime_state,
  output logic [1:0]         dbg_dispatch_state
);

  localparam logic [1:0] IME_OFF   = 2'd0;
  localparam logic [1:0] IME_ARMED = 2'd1;
  localparam logic [1:0] IME_ON    = 2'd2;

  localparam logic [1:0] D_IDLE    = 2'd0;
  localparam logic [1:0] D_ACTIVE  = 2'd1;
  localparam logic [1:0] D_VECTOR  = 2'd2;

  logic [7:0]         r_ie;
  logic [NUM_IRQ-1:0] r_if;
  logic [1:0]         r_ime_state;
  logic [1:0]         r_disp_state;
  logic [7:0]         r_vector;

  logic               w_hit_if;
  logic               w_hit_ie;
  logic               w_wr_if;
  logic               w_wr_ie;
  logic [7:0]         w_ie_eff;
  logic [NUM_IRQ-1:0] w_if_eff;
  logic [NUM_IRQ-1:0] w_sel;
  logic [2:0]         w_sel_idx;
  logic [NUM_IRQ-1:0] w_clr_mask;
  logic               w_vec_cycle;
  logic [1:0]         w_ime_next;
  logic [1:0]         w_disp_next;

  // Address decode and read mux
  assign w_hit_if = (bus_addr == 16'hFF0F);
  assign w_hit_ie = (bus_addr == 16'hFFFF);
  assign w_wr_if  = bus_wren && w_hit_if;
  assign w_wr_ie  = bus_wren && w_hit_ie;
  assign bus_hit  = w_hit_if || w_hit_ie;

  always_comb begin
    bus_rdata = 8'h00;
    if (w_hit_if)      bus_rdata = {3'b111, r_if};
    else if (w_hit_ie) bus_rdata = r_ie;
  end

  // Selection sees this cycle's bus writes: the return-address pushes during
  // dispatch can land on 0xFFFF and cancel or redirect the interrupt.
  assign w_ie_eff    = w_wr_ie ? bus_wdata : r_ie;
  assign w_if_eff    = w_wr_if ? bus_wdata[NUM_IRQ-1:0] : r_if;
  assign w_sel       = w_ie_eff[NUM_IRQ-1:0] & w_if_eff;
  assign w_vec_cycle = (r_disp_state == D_ACTIVE) && dispatch_vector_req;

  // Lowest set index has highest priority
  always_comb begin
    w_sel_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_sel[i]) w_sel_idx = 3'(i);
    end
  end

  always_comb begin
    w_clr_mask = '0;
    if (w_vec_cycle && (w_sel != '0)) w_clr_mask[w_sel_idx] = 1'b1;
  end

  // IME FSM: DI beats everything, dispatch entry disables, RETI enables now
  always_comb begin
    w_ime_next = r_ime_state;
    if (di_cmd)              w_ime_next = IME_OFF;
    else if (dispatch_start) w_ime_next = IME_OFF;
    else if (reti_cmd)       w_ime_next = IME_ON;
    else begin
      case (r_ime_state)
        IME_OFF:   if (ei_cmd)         w_ime_next = IME_ARMED;
        IME_ARMED: if (instr_boundary) w_ime_next = IME_ON;
        IME_ON:                        w_ime_next = IME_ON;
        default:                       w_ime_next = IME_OFF;
      endcase
    end
  end

  always_comb begin
    w_disp_next = r_disp_state;
    case (r_disp_state)
      D_IDLE:   if (dispatch_start)      w_disp_next = D_ACTIVE;
      D_ACTIVE: if (dispatch_vector_req) w_disp_next = D_VECTOR;
      D_VECTOR:                          w_disp_next = D_IDLE;
      default:                           w_disp_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ie         <= 8'h00;
      r_if         <= '0;
      r_ime_state  <= IME_OFF;
      r_disp_state <= D_IDLE;
      r_vector     <= 8'h00;
    end else begin
      r_ie         <= w_ie_eff;
      // Write, then dispatch clear, then new requests OR-ed in last
      r_if         <= (w_if_eff & ~w_clr_mask) | irq_req;
      r_ime_state  <= w_ime_next;
      r_disp_state <= w_disp_next;
      if (w_vec_cycle) begin
        r_vector <= (w_sel != '0) ? {2'b01, w_sel_idx, 3'b000} : 8'h00;
      end
    end
  end

  assign ime                    = (r_ime_state == IME_ON);
  assign wake                   = |(r_ie[NUM_IRQ-1:0] & r_if);
  assign int_pending            = ime && wake;
  assign write_interrupt_vector = (r_disp_state == D_VECTOR);
  assign interrupt_vector       = r_vector;
  assign dbg_ime_state          = r_ime_state;
  assign dbg_dispatch_state     = r_disp_state;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed testbench for gb_cpu_interrupt_ctrl. Inputs change 1 ns after the
// rising edge; outputs are checked at that point, i.e. after the edge settled.

module tb_gb_cpu_interrupt_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  irq_req;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wren;
  logic [7:0]  bus_rdata;
  logic        bus_hit;
  logic        ei_cmd, di_cmd, reti_cmd, instr_boundary;
  logic        dispatch_start, dispatch_vector_req;
  logic        int_pending, wake, ime, write_interrupt_vector;
  logic [7:0]  interrupt_vector;
  logic [1:0]  dbg_ime_state, dbg_dispatch_state;

  int n_checks = 0;
  int n_fail   = 0;

  gb_cpu_interrupt_ctrl #(.NUM_IRQ(5)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .irq_req                (irq_req),
    .bus_addr               (bus_addr),
    .bus_wdata              (bus_wdata),
    .bus_wren               (bus_wren),
    .bus_rdata              (bus_rdata),
    .bus_hit                (bus_hit),
    .ei_cmd                 (ei_cmd),
    .di_cmd                 (di_cmd),
    .reti_cmd               (reti_cmd),
    .instr_boundary         (instr_boundary),
    .dispatch_start         (dispatch_start),
    .dispatch_vector_req    (dispatch_vector_req),
    .int_pending            (int_pending),
    .wake                   (wake),
    .ime                    (ime),
    .write_interrupt_vector (write_interrupt_vector),
    .interrupt_vector       (interrupt_vector),
    .dbg_ime_state          (dbg_ime_state),
    .dbg_dispatch_state     (dbg_dispatch_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; leaves time 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    irq_req = 5'h00; bus_wren = 1'b0;
    ei_cmd = 1'b0; di_cmd = 1'b0; reti_cmd = 1'b0; instr_boundary = 1'b0;
    dispatch_start = 1'b0; dispatch_vector_req = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus_addr = addr; bus_wdata = data; bus_wren = 1'b1;
    tick();
    bus_wren = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus_addr = addr;
    #1;
    check(tag, {8'h00, bus_rdata}, {8'h00, exp});
  endtask

  initial begin
    clear_strobes();
    bus_addr = 16'h0000; bus_wdata = 8'h00;
    reset = 1'b0;

    // Reset state
    #3;
    check("rst_pending", {15'd0, int_pending}, 16'h0);
    check("rst_wake", {15'd0, wake}, 16'h0);
    check("rst_ime", {15'd0, ime}, 16'h0);
    check("rst_wiv", {15'd0, write_interrupt_vector}, 16'h0);
    check("rst_vec", {8'h00, interrupt_vector}, 16'h00);
    read_check("rst_if_read", 16'hFF0F, 8'hE0);
    check("rst_hit_if", {15'd0, bus_hit}, 16'h1);
    read_check("rst_ie_read", 16'hFFFF, 8'h00);
    read_check("miss_read", 16'h1234, 8'h00);
    check("miss_hit", {15'd0, bus_hit}, 16'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Bus access
    bus_write(16'hFF0F, 8'hFF);
    read_check("if_ff", 16'hFF0F, 8'hFF);
    bus_write(16'hFF0F, 8'h00);
    read_check("if_00", 16'hFF0F, 8'hE0);
    bus_write(16'hFFFF, 8'hA5);
    read_check("ie_a5", 16'hFFFF, 8'hA5);
    bus_addr = 16'hFFFF; bus_wdata = 8'h5A; bus_wren = 1'b1;
    #1;
    check("rd_during_wr_old", {8'h00, bus_rdata}, 16'hA5);
    tick(); bus_wren = 1'b0;
    read_check("ie_5a", 16'hFFFF, 8'h5A);

    // EI delay
    bus_write(16'hFFFF, 8'h04);
    bus_write(16'hFF0F, 8'h04);
    check("ei_wake", {15'd0, wake}, 16'h1);
    check("ei_pend_pre", {15'd0, int_pending}, 16'h0);
    ei_cmd = 1'b1; tick(); ei_cmd = 1'b0;
    check("ei_armed_ime", {15'd0, ime}, 16'h0);
    check("ei_armed_pend", {15'd0, int_pending}, 16'h0);
    tick();
    check("ei_wait_pend", {15'd0, int_pending}, 16'h0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_b1_ime", {15'd0, ime}, 16'h1);
    check("ei_b1_pend", {15'd0, int_pending}, 16'h1);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_b2_pend", {15'd0, int_pending}, 16'h1);

    // Priority dispatch: IE=1F, IF=12 -> LCD STAT (bit 1) -> 0x48
    bus_write(16'hFFFF, 8'h1F);
    bus_write(16'hFF0F, 8'h12);
    dispatch_start = 1'b1; tick(); dispatch_start = 1'b0;
    check("pri_ime_off", {15'd0, ime}, 16'h0);
    check("pri_pend_off", {15'd0, int_pending}, 16'h0);
    check("pri_no_pulse", {15'd0, write_interrupt_vector}, 16'h0);
    tick(); tick();
    check("pri_no_pulse2", {15'd0, write_interrupt_vector}, 16'h0);
    dispatch_vector_req = 1'b1; tick(); dispatch_vector_req = 1'b0;
    check("pri_pulse", {15'd0, write_interrupt_vector}, 16'h1);
    check("pri_vec", {8'h00, interrupt_vector}, 16'h48);
    tick();
    check("pri_pulse_end", {15'd0, write_interrupt_vector}, 16'h0);
    check("pri_vec_hold", {8'h00, interrupt_vector}, 16'h48);
    read_check("pri_if", 16'hFF0F, 8'hF0);
    check("pri_ime", {15'd0, ime}, 16'h0);

    // Cancelled dispatch: IE cleared in the vector cycle. Also RETI.
    bus_write(16'hFFFF, 8'h04);
    bus_write(16'hFF0F, 8'h04);
    reti_cmd = 1'b1; tick(); reti_cmd = 1'b0;
    check("reti_ime", {15'd0, ime}, 16'h1);
    check("can_pend", {15'd0, int_pending}, 16'h1);
    dispatch_start = 1'b1; tick(); dispatch_start = 1'b0;
    tick();
    bus_addr = 16'hFFFF; bus_wdata = 8'h00; bus_wren = 1'b1;
    dispatch_vector_req = 1'b1; tick();
    dispatch_vector_req = 1'b0; bus_wren = 1'b0;
    check("can_pulse", {15'd0, write_interrupt_vector}, 16'h1);
    check("can_vec", {8'h00, interrupt_vector}, 16'h00);
    read_check("can_if", 16'hFF0F, 8'hE4);
    read_check("can_ie", 16'hFFFF, 8'h00);
    tick();

    // New request beats dispatch clear of the same bit
    bus_write(16'hFFFF, 8'h01);
    bus_write(16'hFF0F, 8'h01);
    dispatch_start = 1'b1; tick(); dispatch_start = 1'b0;
    irq_req = 5'h01; dispatch_vector_req = 1'b1; tick();
    irq_req = 5'h00; dispatch_vector_req = 1'b0;
    check("rvc_vec", {8'h00, interrupt_vector}, 16'h40);
    read_check("rvc_if", 16'hFF0F, 8'hE1);
    tick();

    // irq_req visible one cycle later
    bus_write(16'hFF0F, 8'h00);
    bus_write(16'hFFFF, 8'h08);
    irq_req = 5'h08;
    #1;
    check("irq_wake_pre", {15'd0, wake}, 16'h0);
    tick(); irq_req = 5'h00;
    check("irq_wake", {15'd0, wake}, 16'h1);
    read_check("irq_if", 16'hFF0F, 8'hE8);

    // DI cancels an armed EI
    ei_cmd = 1'b1; tick(); ei_cmd = 1'b0;
    di_cmd = 1'b1; tick(); di_cmd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
      check("di_cancel_ime", {15'd0, ime}, 16'h0);
    end
    ei_cmd = 1'b1; di_cmd = 1'b1; tick(); ei_cmd = 1'b0; di_cmd = 1'b0;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("di_wins_ime", {15'd0, ime}, 16'h0);

    // dispatch_vector_req while idle is ignored
    dispatch_vector_req = 1'b1; tick(); dispatch_vector_req = 1'b0;
    check("idle_req_pulse", {15'd0, write_interrupt_vector}, 16'h0);
    check("idle_req_vec", {8'h00, interrupt_vector}, 16'h40);

    // Reset mid-dispatch aborts it
    dispatch_start = 1'b1; tick(); dispatch_start = 1'b0;
    reset = 1'b0;
    #1;
    check("rmd_vec", {8'h00, interrupt_vector}, 16'h00);
    read_check("rmd_ie", 16'hFFFF, 8'h00);
    tick();
    reset = 1'b1;
    dispatch_vector_req = 1'b1; tick(); dispatch_vector_req = 1'b0;
    check("rmd_pulse1", {15'd0, write_interrupt_vector}, 16'h0);
    tick();
    check("rmd_pulse2", {15'd0, write_interrupt_vector}, 16'h0);
    check("rmd_vec2", {8'h00, interrupt_vector}, 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
# gb_cpu_interrupt_ctrl

Interrupt controller for the Game Boy CPU. It owns the IE (0xFFFF) and IF (0xFF0F) registers and the IME flag, including EI delay, DI and RETI handling. It tells the control unit when an interrupt is pending and runs the dispatch handshake. It drives the register file's PC-overwrite port (`write_interrupt_vector` / `interrupt_vector`) with the highest-priority vector.

## Interface
- `NUM_IRQ`, 5, number of interrupt sources. Bit 0 VBlank, 1 LCD STAT, 2 Timer, 3 Serial, 4 Joypad; bit 0 has highest priority.
- `clk`  input  1  machine clock
- `reset`  input  1  asynchronous, active-low reset
- `irq_req`  input  5  single-cycle request pulses from peripherals
- `bus_addr`  input  16  CPU data-bus address
- `bus_wdata`  input  8  CPU data-bus write data
- `bus_wren`  input  1  bus write strobe
- `bus_rdata`  output  8  read data for IE/IF (combinational); 0x00 when `bus_hit`=0
- `bus_hit`  output  1  `bus_addr` is 0xFF0F or 0xFFFF
- `ei_cmd`, `di_cmd`, `reti_cmd`  input  1 each  one-cycle strobes from the control unit
- `instr_boundary`  input  1  one-cycle strobe at each opcode fetch
- `dispatch_start`  input  1  control unit enters the 5 M-cycle dispatch sequence
- `dispatch_vector_req`  input  1  control unit's PC-load cycle within dispatch
- `int_pending`  output  1  IME && |(IE & IF[4:0])
- `wake`  output  1  |(IE[4:0] & IF[4:0]), independent of IME; exits HALT
- `ime`  output  1  current IME
- `write_interrupt_vector`  output  1  one-cycle pulse that loads PC
- `interrupt_vector`  output  8  low byte of vector; PC high byte is forced to 0x00 by the regfile

## Operation
- **Registers**
  - IE: 8 bits, fully writable and readable.
  - IF: 5 bits; reads return {3'b111, IF}.
  - Every register updates on posedge `clk`.
- **IF update per cycle**, applied in order:
  1. A bus write to 0xFF0F loads `bus_wdata[4:0]`.
  2. A dispatch clear removes the serviced bit.
  3. `irq_req` bits are OR-ed in last, so a new request wins over both a write and a clear.
- **IME sequencing**, 3-state FSM: `IME_OFF`, `IME_ARMED`, `IME_ON`.
  - `ei_cmd` from `IME_OFF` goes to `IME_ARMED`. `ei_cmd` while `IME_ON` is ignored.
  - `IME_ARMED` goes to `IME_ON` at the first `instr_boundary` after the `ei_cmd` cycle. IME therefore becomes 1 after the instruction following EI.
  - `di_cmd` goes to `IME_OFF` from any state, cancelling an armed EI. `di_cmd` wins over a simultaneous `ei_cmd`.
  - `reti_cmd` goes to `IME_ON` immediately.
  - `dispatch_start` goes to `IME_OFF`.
  - `ime` = (state == `IME_ON`).
- **Dispatch FSM**, states `D_IDLE`, `D_ACTIVE`, `D_VECTOR`.
  - `D_IDLE` to `D_ACTIVE` on `dispatch_start`.
  - `D_ACTIVE` to `D_VECTOR` on `dispatch_vector_req`. In that cycle, compute sel = IE & IF[4:0] using current values, after any same-cycle IE/IF bus write; the SP pushes can write IE.
    - sel nonzero, lowest set index n: latch vector = 0x40 + 8·n and clear IF[n].
    - sel zero (cancelled dispatch): latch vector = 0x00 and leave IF unchanged.
  - `D_VECTOR`: `write_interrupt_vector`=1 for exactly this one cycle, then return to `D_IDLE`.
  - `dispatch_vector_req` while in `D_IDLE` is ignored.
  - `dispatch_start` while not in `D_IDLE` is ignored.
- Priority arithmetic: vector = {2'b01, n[2:0], 3'b000}, where n is in 0–4.

## Timing
- **Reset values** while `reset`=0, asynchronously:
  - IE=0x00, IF=0x00, IME state `IME_OFF`, dispatch `D_IDLE`.
  - `int_pending`=0, `wake`=0, `ime`=0, `write_interrupt_vector`=0, `interrupt_vector`=0x00.
  - `bus_rdata`=0x00 and `bus_hit`=0 unless the address decodes; an IF read during reset returns 0xE0.
- An `irq_req` pulse is visible in IF, `wake` and `int_pending` one cycle later.
- `bus_rdata` is combinational from the current register values. A read in the same cycle as a write returns the old value.
- `dispatch_vector_req` in cycle t produces the `write_interrupt_vector` pulse in cycle t+1. `interrupt_vector` is held stable from t+1 until the next dispatch.
- Reset asserted mid-dispatch aborts the dispatch; no pulse is emitted after reset release.

## Test plan
- **EI delay:** IE=0x04, IF=0x04, IME off. Pulse `ei_cmd`, then `instr_boundary` twice → `int_pending` rises only after the first boundary and stays 1.
- **Priority:** IE=0x1F, IF=0x12, IME on. Run dispatch → `interrupt_vector`=0x48, one-cycle `write_interrupt_vector`, IF reads 0xF0, `ime`=0.
- **Cancel:** dispatch pending on Timer, then a write of IE=0x00 in the `dispatch_vector_req` cycle → `interrupt_vector`=0x00, IF[2] still 1.
- **Request vs clear:** `irq_req`=0x01 in the same cycle that dispatch clears IF[0] → IF[0]=1 afterwards.
- **DI cancels EI:** `ei_cmd`, then `di_cmd` before any boundary, then 3 boundaries → `ime`=0 throughout. Also `reti_cmd` → `ime`=1 the next cycle.
- **Bus:** write 0xFF to 0xFF0F → read returns 0xFF. Write 0x00 → read returns 0xE0. A write to 0xFFFF of 0xA5 reads back 0xA5. Reset mid-dispatch → no vector pulse.
